multi_color_tracker: RTL and testbench

Per-pixel, multi-channel colour-blob tracker for the OV2640 RGB565 stream. Tracks up to NUM_CH independent colour windows in one pass and reports a bounding box, centre and pixel count per channel once per frame. Adds run-start-corrected boxes, saturating arithmetic and detection hold-off. Sits between the camera capture front-end and the overlay/servo logic, on the camera DCLK domain.

---
 rtl/multi_color_tracker_pkg.sv | 47 ++++
 rtl/color_tracker_channel.sv | 170 +++++++++++++++++
 rtl/multi_color_tracker.sv | 122 ++++++++++++
 tb/tb_multi_color_tracker.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_color_tracker_pkg.sv
// Shared types and helpers for the multi-channel RGB565 colour tracker.
package multi_color_tracker_pkg;

  localparam int unsigned PIX_W      = 16;
  localparam int unsigned R_W        = 5;
  localparam int unsigned G_W        = 6;
  localparam int unsigned B_W        = 5;
  localparam int unsigned R_LSB      = 11;
  localparam int unsigned G_LSB      = 5;
  localparam int unsigned B_LSB      = 0;
  localparam int unsigned RESET_HALF = 20;

  // One RGB565 pixel or window bound, fields in stream order (R high).
  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  function automatic logic [R_W-1:0] get_r(input logic [PIX_W-1:0] px);
    return px[R_LSB +: R_W];
  endfunction

  function automatic logic [G_W-1:0] get_g(input logic [PIX_W-1:0] px);
    return px[G_LSB +: G_W];
  endfunction

  function automatic logic [B_W-1:0] get_b(input logic [PIX_W-1:0] px);
    return px[B_LSB +: B_W];
  endfunction

  function automatic rgb565_t unpack_rgb565(input logic [PIX_W-1:0] px);
    rgb565_t f;
    f.r = get_r(px);
    f.g = get_g(px);
    f.b = get_b(px);
    return f;
  endfunction

  // Inclusive per-field window test.
  function automatic logic in_window(input rgb565_t px, input rgb565_t lo, input rgb565_t hi);
    return (px.r >= lo.r) && (px.r <= hi.r) &&
           (px.g >= lo.g) && (px.g <= hi.g) &&
           (px.b >= lo.b) && (px.b <= hi.b);
  endfunction

endpackage

// File: rtl/color_tracker_channel.sv
// One colour channel: window match, run streak, box/count accumulators,
// detection hold-off and the per-frame result registers.
module color_tracker_channel
  import multi_color_tracker_pkg::*;
#(
  parameter int unsigned H_RES       = 320,
  parameter int unsigned V_RES       = 240,
  parameter int unsigned X_W         = 10,
  parameter int unsigned Y_W         = 10,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned MIN_RUN     = 4,
  parameter int unsigned MIN_COUNT   = 100,
  parameter int unsigned MARGIN      = 4,
  parameter int unsigned HOLD_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             line_active_i,
  input  logic             pix_valid_i,
  input  logic             eof_i,
  input  logic [X_W-1:0]   curr_x_i,
  input  logic [Y_W-1:0]   curr_y_i,
  input  rgb565_t          pix_i,
  input  rgb565_t          win_lo_i,
  input  rgb565_t          win_hi_i,
  output logic [X_W-1:0]   obj_x_o,
  output logic [Y_W-1:0]   obj_y_o,
  output logic [X_W-1:0]   obj_half_w_o,
  output logic [Y_W-1:0]   obj_half_h_o,
  output logic [CNT_W-1:0] obj_count_o,
  output logic             obj_detected_o
);

  localparam int unsigned RUN_W  = $clog2(MIN_RUN + 1);
  localparam int unsigned MISS_W = $clog2(HOLD_FRAMES + 2);
  localparam int unsigned CNT_W1 = CNT_W + 1;
  localparam int unsigned X_W1   = X_W + 1;
  localparam int unsigned Y_W1   = Y_W + 1;

  logic [RUN_W-1:0]  streak_q, streak_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [X_W-1:0]    x_min_q, x_min_d, x_max_q, x_max_d;
  logic [Y_W-1:0]    y_min_q, y_min_d, y_max_q, y_max_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [X_W-1:0]    obj_x_q, obj_x_d, half_w_q, half_w_d;
  logic [Y_W-1:0]    obj_y_q, obj_y_d, half_h_q, half_h_d;
  logic [CNT_W-1:0]  obj_count_q, obj_count_d;
  logic              det_q, det_d;

  logic              match_c, run_start_c, run_cont_c, hit_c;
  logic [X_W-1:0]    x_start_c, x_lo_c, dx_c;
  logic [Y_W-1:0]    dy_c;
  logic [CNT_W1-1:0] cnt_sum_c;
  logic [X_W1-1:0]   sum_x_c;
  logic [Y_W1-1:0]   sum_y_c;

  // Window match and run classification on the pre-increment streak.
  assign match_c     = in_window(pix_i, win_lo_i, win_hi_i);
  assign run_start_c = line_active_i && pix_valid_i && match_c && (streak_q == RUN_W'(MIN_RUN - 1));
  assign run_cont_c  = line_active_i && pix_valid_i && match_c && (streak_q == RUN_W'(MIN_RUN));

  // A run start back-dates x_min to the first pixel of the run.
  assign x_start_c = (curr_x_i >= X_W'(MIN_RUN - 1)) ? curr_x_i - X_W'(MIN_RUN - 1) : '0;
  assign x_lo_c    = run_start_c ? x_start_c : curr_x_i;
  assign cnt_sum_c = {1'b0, count_q} + (run_start_c ? CNT_W1'(MIN_RUN) : CNT_W1'(1));

  // Frame-end box arithmetic; sums carry one extra bit before halving.
  assign hit_c   = (count_q >= CNT_W'(MIN_COUNT));
  assign sum_x_c = {1'b0, x_min_q} + {1'b0, x_max_q};
  assign sum_y_c = {1'b0, y_min_q} + {1'b0, y_max_q};
  assign dx_c    = x_max_q - x_min_q;
  assign dy_c    = y_max_q - y_min_q;

  // Next-state for streak, accumulators, hold-off and results.
  always_comb begin
    streak_d    = streak_q;
    count_d     = count_q;
    x_min_d     = x_min_q;
    x_max_d     = x_max_q;
    y_min_d     = y_min_q;
    y_max_d     = y_max_q;
    miss_d      = miss_q;
    obj_x_d     = obj_x_q;
    obj_y_d     = obj_y_q;
    half_w_d    = half_w_q;
    half_h_d    = half_h_q;
    obj_count_d = obj_count_q;
    det_d       = det_q;

    if (!line_active_i) begin
      streak_d = '0;
    end else if (pix_valid_i) begin
      if (!match_c) begin
        streak_d = '0;
      end else if (!run_cont_c) begin
        streak_d = streak_q + RUN_W'(1);
      end
    end

    if (run_start_c || run_cont_c) begin
      count_d = cnt_sum_c[CNT_W] ? '1 : cnt_sum_c[CNT_W-1:0];
      if (x_lo_c < x_min_q)   x_min_d = x_lo_c;
      if (curr_x_i > x_max_q) x_max_d = curr_x_i;
      if (curr_y_i < y_min_q) y_min_d = curr_y_i;
      if (curr_y_i > y_max_q) y_max_d = curr_y_i;
    end

    if (eof_i) begin
      obj_count_d = count_q;
      if (hit_c) begin
        obj_x_d  = sum_x_c[X_W:1];
        obj_y_d  = sum_y_c[Y_W:1];
        half_w_d = (dx_c >> 1) + X_W'(MARGIN);
        half_h_d = (dy_c >> 1) + Y_W'(MARGIN);
        det_d    = 1'b1;
        miss_d   = '0;
      end else if (miss_q == MISS_W'(HOLD_FRAMES)) begin
        det_d = 1'b0;
      end else begin
        miss_d = miss_q + MISS_W'(1);
      end
      count_d = '0;
      x_min_d = X_W'(H_RES - 1);
      x_max_d = '0;
      y_min_d = Y_W'(V_RES - 1);
      y_max_d = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_q    <= '0;
      count_q     <= '0;
      x_min_q     <= X_W'(H_RES - 1);
      x_max_q     <= '0;
      y_min_q     <= Y_W'(V_RES - 1);
      y_max_q     <= '0;
      miss_q      <= '0;
      obj_x_q     <= X_W'(H_RES / 2);
      obj_y_q     <= Y_W'(V_RES / 2);
      half_w_q    <= X_W'(RESET_HALF);
      half_h_q    <= Y_W'(RESET_HALF);
      obj_count_q <= '0;
      det_q       <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      count_q     <= count_d;
      x_min_q     <= x_min_d;
      x_max_q     <= x_max_d;
      y_min_q     <= y_min_d;
      y_max_q     <= y_max_d;
      miss_q      <= miss_d;
      obj_x_q     <= obj_x_d;
      obj_y_q     <= obj_y_d;
      half_w_q    <= half_w_d;
      half_h_q    <= half_h_d;
      obj_count_q <= obj_count_d;
      det_q       <= det_d;
    end
  end

  assign obj_x_o        = obj_x_q;
  assign obj_y_o        = obj_y_q;
  assign obj_half_w_o   = half_w_q;
  assign obj_half_h_o   = half_h_q;
  assign obj_count_o    = obj_count_q;
  assign obj_detected_o = det_q;

endmodule

// File: rtl/multi_color_tracker.sv
// Multi-channel colour-blob tracker: coordinate counters, sync edge
// detection and one color_tracker_channel per colour window.
module multi_color_tracker
  import multi_color_tracker_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned H_RES       = 320,
  parameter int unsigned V_RES       = 240,
  parameter int unsigned X_W         = 10,
  parameter int unsigned Y_W         = 10,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned MIN_RUN     = 4,
  parameter int unsigned MIN_COUNT   = 100,
  parameter int unsigned MARGIN      = 4,
  parameter int unsigned HOLD_FRAMES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vsync,
  input  logic                    href,
  input  logic                    pixel_valid,
  input  logic [PIX_W-1:0]        pixel_data,
  input  logic [R_W*NUM_CH-1:0]   r_min,
  input  logic [R_W*NUM_CH-1:0]   r_max,
  input  logic [G_W*NUM_CH-1:0]   g_min,
  input  logic [G_W*NUM_CH-1:0]   g_max,
  input  logic [B_W*NUM_CH-1:0]   b_min,
  input  logic [B_W*NUM_CH-1:0]   b_max,
  output logic [X_W*NUM_CH-1:0]   obj_x,
  output logic [Y_W*NUM_CH-1:0]   obj_y,
  output logic [X_W*NUM_CH-1:0]   obj_half_w,
  output logic [Y_W*NUM_CH-1:0]   obj_half_h,
  output logic [CNT_W*NUM_CH-1:0] obj_count,
  output logic [NUM_CH-1:0]       obj_detected,
  output logic                    frame_done
);

  logic           vsync_q, href_q, frame_done_q;
  logic [X_W-1:0] curr_x_q, curr_x_d;
  logic [Y_W-1:0] curr_y_q, curr_y_d;
  logic           eof_c, href_fall_c, line_active_c, pix_valid_c;
  rgb565_t        pix_c;

  // Registered sync edges; frame end is the first cycle vsync is seen low.
  assign eof_c         = vsync_q & ~vsync;
  assign href_fall_c   = href_q & ~href;
  assign line_active_c = vsync & href;
  assign pix_valid_c   = line_active_c & pixel_valid;
  assign pix_c         = unpack_rgb565(pixel_data);

  // Saturating pixel/line coordinates of the pixel currently presented.
  always_comb begin
    curr_x_d = curr_x_q;
    curr_y_d = curr_y_q;
    if (!line_active_c) begin
      curr_x_d = '0;
    end else if (pixel_valid && (curr_x_q != X_W'(H_RES - 1))) begin
      curr_x_d = curr_x_q + X_W'(1);
    end
    if (!vsync) begin
      curr_y_d = '0;
    end else if (href_fall_c && (curr_y_q != Y_W'(V_RES - 1))) begin
      curr_y_d = curr_y_q + Y_W'(1);
    end
  end

  // Coordinate, edge-detect and frame_done registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      frame_done_q <= 1'b0;
      curr_x_q     <= '0;
      curr_y_q     <= '0;
    end else begin
      vsync_q      <= vsync;
      href_q       <= href;
      frame_done_q <= eof_c;
      curr_x_q     <= curr_x_d;
      curr_y_q     <= curr_y_d;
    end
  end

  assign frame_done = frame_done_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rgb565_t win_lo, win_hi;

    assign win_lo = {r_min[R_W*c +: R_W], g_min[G_W*c +: G_W], b_min[B_W*c +: B_W]};
    assign win_hi = {r_max[R_W*c +: R_W], g_max[G_W*c +: G_W], b_max[B_W*c +: B_W]};

    color_tracker_channel #(
      .H_RES       (H_RES),
      .V_RES       (V_RES),
      .X_W         (X_W),
      .Y_W         (Y_W),
      .CNT_W       (CNT_W),
      .MIN_RUN     (MIN_RUN),
      .MIN_COUNT   (MIN_COUNT),
      .MARGIN      (MARGIN),
      .HOLD_FRAMES (HOLD_FRAMES)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .line_active_i  (line_active_c),
      .pix_valid_i    (pix_valid_c),
      .eof_i          (eof_c),
      .curr_x_i       (curr_x_q),
      .curr_y_i       (curr_y_q),
      .pix_i          (pix_c),
      .win_lo_i       (win_lo),
      .win_hi_i       (win_hi),
      .obj_x_o        (obj_x[X_W*c +: X_W]),
      .obj_y_o        (obj_y[Y_W*c +: Y_W]),
      .obj_half_w_o   (obj_half_w[X_W*c +: X_W]),
      .obj_half_h_o   (obj_half_h[Y_W*c +: Y_W]),
      .obj_count_o    (obj_count[CNT_W*c +: CNT_W]),
      .obj_detected_o (obj_detected[c])
    );
  end

endmodule

// File: tb/tb_multi_color_tracker.sv
// Self-checking bench: table of frames with expected per-channel results
// queued at frame end and checked on frame_done, plus reset and saturation cases.
module tb_multi_color_tracker;

  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] BLUE  = 16'h001F;
  localparam logic [15:0] BLACK = 16'h0000;

  typedef struct {
    int x0, y0, w0, h0, c0, d0;
    int x1, y1, w1, h1, c1, d1;
  } exp_t;

  typedef struct {
    int   ax0, ax1, ay0, ay1;
    int   bx0, bx1, by0, by1;
    int   runs, nlines, vgap;
    exp_t e;
  } vec_t;

  logic        clk, rst_n;
  logic        vsync, href, pixel_valid;
  logic [15:0] pixel_data;
  logic [9:0]  r_min, r_max, b_min, b_max;
  logic [11:0] g_min, g_max;
  logic [19:0] obj_x, obj_y, obj_half_w, obj_half_h;
  logic [39:0] obj_count;
  logic [1:0]  obj_detected;
  logic        frame_done;

  logic        v2, h2, pv2;
  logic [15:0] pd2;
  logic [4:0]  r_min2, r_max2, b_min2, b_max2;
  logic [5:0]  g_min2, g_max2;
  logic [9:0]  x2, y2, w2, hh2;
  logic [7:0]  cnt2;
  logic [0:0]  det2;
  logic        fd2;

  int   n_tests, n_fail, n_pushed, n_pulses;
  exp_t exp_q[$];
  vec_t vecs[6];
  bit   fd_prev;

  multi_color_tracker dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .href(href),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .r_min(r_min), .r_max(r_max), .g_min(g_min), .g_max(g_max),
    .b_min(b_min), .b_max(b_max),
    .obj_x(obj_x), .obj_y(obj_y), .obj_half_w(obj_half_w), .obj_half_h(obj_half_h),
    .obj_count(obj_count), .obj_detected(obj_detected), .frame_done(frame_done)
  );

  multi_color_tracker #(
    .NUM_CH(1), .H_RES(32), .V_RES(16), .CNT_W(8)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .vsync(v2), .href(h2),
    .pixel_valid(pv2), .pixel_data(pd2),
    .r_min(r_min2), .r_max(r_max2), .g_min(g_min2), .g_max(g_max2),
    .b_min(b_min2), .b_max(b_max2),
    .obj_x(x2), .obj_y(y2), .obj_half_w(w2), .obj_half_h(hh2),
    .obj_count(cnt2), .obj_detected(det2), .frame_done(fd2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    check({tag, " ch0 obj_x"},      int'(obj_x[9:0]),          e.x0);
    check({tag, " ch0 obj_y"},      int'(obj_y[9:0]),          e.y0);
    check({tag, " ch0 half_w"},     int'(obj_half_w[9:0]),     e.w0);
    check({tag, " ch0 half_h"},     int'(obj_half_h[9:0]),     e.h0);
    check({tag, " ch0 count"},      int'(obj_count[19:0]),     e.c0);
    check({tag, " ch0 detected"},   int'(obj_detected[0]),     e.d0);
    check({tag, " ch1 obj_x"},      int'(obj_x[19:10]),        e.x1);
    check({tag, " ch1 obj_y"},      int'(obj_y[19:10]),        e.y1);
    check({tag, " ch1 half_w"},     int'(obj_half_w[19:10]),   e.w1);
    check({tag, " ch1 half_h"},     int'(obj_half_h[19:10]),   e.h1);
    check({tag, " ch1 count"},      int'(obj_count[39:20]),    e.c1);
    check({tag, " ch1 detected"},   int'(obj_detected[1]),     e.d1);
  endtask

  task automatic check_reset_vals(input string tag);
    exp_t r;
    r = '{160, 120, 20, 20, 0, 0, 160, 120, 20, 20, 0, 0};
    compare_outputs(tag, r);
    check({tag, " frame_done"}, int'(frame_done), 0);
  endtask

  function automatic int line_width(input vec_t v, input int y);
    int w;
    w = 0;
    if (v.runs != 0) return (y < 5) ? 100 : 0;
    if (v.ax0 >= 0 && y >= v.ay0 && y <= v.ay1) w = v.ax1 + 1;
    if (v.bx0 >= 0 && y >= v.by0 && y <= v.by1 && v.bx1 + 1 > w) w = v.bx1 + 1;
    return w;
  endfunction

  function automatic logic [15:0] pix_at(input vec_t v, input int x, input int y);
    if (v.runs != 0) return ((x % 4) != 3) ? RED : BLACK;
    if (v.ax0 >= 0 && x >= v.ax0 && x <= v.ax1 && y >= v.ay0 && y <= v.ay1) return RED;
    if (v.bx0 >= 0 && x >= v.bx0 && x <= v.bx1 && y >= v.by0 && y <= v.by1) return BLUE;
    return BLACK;
  endfunction

  task automatic frame_start();
    vsync = 1'b1; href = 1'b0; pixel_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Lines without content are a one-cycle href pulse; an invalid red cycle
  // is slipped in before x=105 to show pixel_valid gating.
  task automatic drive_lines(input vec_t v);
    int w;
    for (int y = 0; y < v.nlines; y++) begin
      w = line_width(v, y);
      href = 1'b1;
      if (w == 0) begin
        pixel_valid = 1'b0;
        @(negedge clk);
      end else begin
        for (int x = 0; x < w; x++) begin
          if (x == 105) begin
            pixel_valid = 1'b0; pixel_data = RED;
            @(negedge clk);
          end
          pixel_valid = 1'b1;
          pixel_data  = pix_at(v, x, y);
          @(negedge clk);
        end
      end
      href = 1'b0; pixel_valid = 1'b0; pixel_data = BLACK;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic frame_end(input exp_t e, input int gap);
    exp_q.push_back(e);
    n_pushed++;
    vsync = 1'b0; href = 1'b0; pixel_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check({tag, " pending results"}, exp_q.size(), 0);
  endtask

  // Scoreboard side: every frame_done pops one expected frame.
  initial begin
    exp_t e;
    fd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        n_pulses++;
        check("frame_done single cycle", int'(fd_prev), 0);
        check("frame_done has pending frame", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          compare_outputs($sformatf("frame%0d", n_pulses), e);
        end
      end
      fd_prev = frame_done;
    end
  end

  initial begin
    vec_t rv;
    exp_t re;
    int   got;
    n_tests = 0; n_fail = 0; n_pushed = 0; n_pulses = 0;
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; pixel_valid = 1'b0; pixel_data = BLACK;
    v2 = 1'b0; h2 = 1'b0; pv2 = 1'b0; pd2 = BLACK;
    // ch0: red window, ch1: blue window (upper slice)
    r_min = {5'd0, 5'd20};  r_max = {5'd5, 5'd31};
    g_min = {6'd0, 6'd0};   g_max = {6'd10, 6'd15};
    b_min = {5'd20, 5'd0};  b_max = {5'd31, 5'd10};
    r_min2 = 5'd20; r_max2 = 5'd31; g_min2 = 6'd0; g_max2 = 6'd15; b_min2 = 5'd0; b_max2 = 5'd10;

    //         ch0 red block        ch1 blue block       runs lines gap  expected ch0 / ch1
    vecs[0] = '{100, 119, 50, 59,   10, 29, 200, 209,    0, 210, 3,
                '{109, 54, 13, 8, 200, 1,   19, 204, 13, 8, 200, 1}};
    vecs[1] = '{200, 209, 10, 19,   -1, 0, 0, 0,         0, 20, 3,
                '{204, 14, 8, 8, 100, 1,    19, 204, 13, 8, 0, 1}};
    vecs[2] = '{-1, 0, 0, 0,        -1, 0, 0, 0,         1, 5, 3,
                '{204, 14, 8, 8, 0, 1,      19, 204, 13, 8, 0, 1}};
    vecs[3] = '{-1, 0, 0, 0,        -1, 0, 0, 0,         0, 3, 1,
                '{204, 14, 8, 8, 0, 1,      19, 204, 13, 8, 0, 0}};
    vecs[4] = '{-1, 0, 0, 0,        -1, 0, 0, 0,         0, 3, 3,
                '{204, 14, 8, 8, 0, 0,      19, 204, 13, 8, 0, 0}};
    vecs[5] = '{30, 40, 0, 8,       0, 9, 100, 109,      0, 110, 3,
                '{204, 14, 8, 8, 99, 0,     4, 104, 8, 8, 100, 1}};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("after reset");

    for (int i = 0; i < 6; i++) begin
      frame_start();
      drive_lines(vecs[i]);
      frame_end(vecs[i].e, vecs[i].vgap);
    end
    wait_drain("table");

    // Reset pulse mid-frame: partial red block is discarded, lines restart at 0.
    frame_start();
    rv = '{0, 19, 2, 7, -1, 0, 0, 0, 0, 10, 3, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    drive_lines(rv);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("mid-frame reset");
    rv = '{-1, 0, 0, 0, 50, 69, 5, 14, 0, 15, 3, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    drive_lines(rv);
    re = '{160, 120, 20, 20, 0, 0, 59, 9, 13, 8, 200, 1};
    frame_end(re, 3);
    wait_drain("post-reset frame");
    check("frame_done pulses", n_pulses, n_pushed);

    // Full-frame match overrunning both line and frame size on the small instance.
    v2 = 1'b1;
    repeat (2) @(negedge clk);
    for (int l = 0; l < 18; l++) begin
      h2 = 1'b1; pv2 = 1'b1; pd2 = RED;
      repeat (34) @(negedge clk);
      h2 = 1'b0; pv2 = 1'b0; pd2 = BLACK;
      repeat (2) @(negedge clk);
    end
    v2 = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (fd2) got = 1;
    end
    check("sat frame_done seen", got, 1);
    check("sat obj_count", int'(cnt2), 255);
    check("sat obj_x", int'(x2), 15);
    check("sat obj_y", int'(y2), 7);
    check("sat half_w", int'(w2), 19);
    check("sat half_h", int'(hh2), 11);
    check("sat detected", int'(det2), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
